// File: rtl/ppu_pkg.sv
// Shared types, screen defaults, palette table and emphasis helpers for the
// PPU pixel capture path and other palette consumers.
package ppu_pkg;

    localparam logic [8:0] SCREEN_WIDTH_DEFAULT  = 9'd256;
    localparam logic [8:0] SCREEN_HEIGHT_DEFAULT = 9'd240;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [23:0] rgb;
        logic        last_line;
        logic        last_frame;
    } pixel_beat_t;

    // 64-entry {R,G,B} palette; entry 0x3E is a non-black test colour.
    localparam logic [23:0] PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h8040FF, 24'h000000
    };

    // Scale one channel to 3/4 using 10-bit math (255*3 fits), truncated.
    function automatic logic [7:0] attenuate(input logic [7:0] c);
        logic [9:0] t;
        t = {2'b00, c} * 10'd3;
        return t[9:2];
    endfunction

    // Emphasis {B,G,R}: each set bit attenuates the other two channels;
    // all three bits set attenuates every channel.
    function automatic logic [23:0] apply_emphasis(input logic [23:0] rgb,
                                                   input logic [2:0]  emph);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        if (emph[1] | emph[2]) r = attenuate(r);
        if (emph[0] | emph[2]) g = attenuate(g);
        if (emph[0] | emph[1]) b = attenuate(b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/ppu_palette_rom.sv
// 64x24 palette ROM with a registered read port (one cycle latency).
module ppu_palette_rom
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [23:0] rd_data
);

    logic [23:0] rd_data_d;
    logic [23:0] rd_data_q;

    // Table lookup for the addressed entry.
    always_comb begin
        rd_data_d = PALETTE[addr];
    end

    // Registered read; contents are constant so no reset is needed.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ppu_pixel_capture.sv
// Turns the raw PPU pixel stream into addressed RGB write beats.
// Handshake: wr_en is a one-cycle valid with no ready; the consumer must take
// every beat. wr_x/wr_y/wr_rgb hold their last values while wr_en is low.
// Latency is fixed at two cycles from an accepted px_out to wr_en.
module ppu_pixel_capture
    import ppu_pkg::*;
#(
    parameter logic [8:0] ISCREEN_WIDTH  = SCREEN_WIDTH_DEFAULT,
    parameter logic [8:0] ISCREEN_HEIGHT = SCREEN_HEIGHT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  px_data,
    input  logic        px_out,
    input  logic        trigger_frame,
    input  logic        greyscale,
    input  logic [2:0]  emphasis,
    output logic        wr_en,
    output logic [8:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic [23:0] wr_rgb,
    output logic        line_done,
    output logic        frame_done,
    output logic        overrun,
    output logic [1:0]  dbg_state
);

    // Position tracking
    cap_state_t  state_d, state_q;
    logic [8:0]  x_d, x_q;
    logic [8:0]  y_d, y_q;
    logic        overrun_d, overrun_q;

    logic        accept;
    logic [8:0]  cap_x;
    logic [8:0]  cap_y;
    logic        cap_last_line;
    logic        cap_last_frame;
    logic [5:0]  rom_addr;
    logic [23:0] rom_data;

    // Stage 1 (aligned with the registered ROM read)
    logic        s1_valid_d, s1_valid_q;
    logic [8:0]  s1_x_d, s1_x_q;
    logic [8:0]  s1_y_d, s1_y_q;
    logic [2:0]  s1_emph_d, s1_emph_q;
    logic        s1_last_line_d, s1_last_line_q;
    logic        s1_last_frame_d, s1_last_frame_q;

    // Stage 2 (output register)
    logic        out_valid_d, out_valid_q;
    pixel_beat_t beat_d, beat_q;

    logic        unused_px_bits;
    assign unused_px_bits = ^px_data[7:6];

    // Frame position FSM: trigger_frame restarts at (0,0) from any state and
    // a pixel arriving with it is taken as (0,0).
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        overrun_d      = overrun_q;
        accept         = 1'b0;
        cap_x          = x_q;
        cap_y          = y_q;
        if (trigger_frame) begin
            cap_x     = 9'd0;
            cap_y     = 9'd0;
            x_d       = 9'd0;
            y_d       = 9'd0;
            overrun_d = 1'b0;
            state_d   = ACTIVE;
        end
        cap_last_line  = (cap_x == ISCREEN_WIDTH - 9'd1);
        cap_last_frame = cap_last_line && (cap_y == ISCREEN_HEIGHT - 9'd1);
        if (px_out) begin
            if (trigger_frame || state_q == ACTIVE) begin
                accept = 1'b1;
                if (cap_last_frame) begin
                    x_d     = 9'd0;
                    y_d     = 9'd0;
                    state_d = DONE;
                end else if (cap_last_line) begin
                    x_d = 9'd0;
                    y_d = cap_y + 9'd1;
                end else begin
                    x_d = cap_x + 9'd1;
                end
            end else if (state_q == DONE) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Greyscale keeps only the luma row of the palette index.
    always_comb begin
        rom_addr = greyscale ? (px_data[5:0] & 6'h30) : px_data[5:0];
    end

    ppu_palette_rom u_rom (
        .clk     (clk),
        .addr    (rom_addr),
        .rd_data (rom_data)
    );

    // Stage 1 tags travel alongside the ROM read; held when idle.
    always_comb begin
        s1_valid_d      = accept;
        s1_x_d          = s1_x_q;
        s1_y_d          = s1_y_q;
        s1_emph_d       = s1_emph_q;
        s1_last_line_d  = s1_last_line_q;
        s1_last_frame_d = s1_last_frame_q;
        if (accept) begin
            s1_x_d          = cap_x;
            s1_y_d          = cap_y;
            s1_emph_d       = emphasis;
            s1_last_line_d  = cap_last_line;
            s1_last_frame_d = cap_last_frame;
        end
    end

    // Stage 2 applies emphasis and registers the beat; fields hold when idle.
    always_comb begin
        out_valid_d = s1_valid_q;
        beat_d      = beat_q;
        if (s1_valid_q) begin
            beat_d.x          = s1_x_q;
            beat_d.y          = s1_y_q;
            beat_d.rgb        = apply_emphasis(rom_data, s1_emph_q);
            beat_d.last_line  = s1_last_line_q;
            beat_d.last_frame = s1_last_frame_q;
        end
    end

    // All state registers with synchronous reset; reset drops in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            x_q             <= 9'd0;
            y_q             <= 9'd0;
            overrun_q       <= 1'b0;
            s1_valid_q      <= 1'b0;
            s1_x_q          <= 9'd0;
            s1_y_q          <= 9'd0;
            s1_emph_q       <= 3'd0;
            s1_last_line_q  <= 1'b0;
            s1_last_frame_q <= 1'b0;
            out_valid_q     <= 1'b0;
            beat_q          <= '0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            overrun_q       <= overrun_d;
            s1_valid_q      <= s1_valid_d;
            s1_x_q          <= s1_x_d;
            s1_y_q          <= s1_y_d;
            s1_emph_q       <= s1_emph_d;
            s1_last_line_q  <= s1_last_line_d;
            s1_last_frame_q <= s1_last_frame_d;
            out_valid_q     <= out_valid_d;
            beat_q          <= beat_d;
        end
    end

    assign wr_en      = out_valid_q;
    assign wr_x       = beat_q.x;
    assign wr_y       = beat_q.y;
    assign wr_rgb     = beat_q.rgb;
    assign line_done  = out_valid_q & beat_q.last_line;
    assign frame_done = out_valid_q & beat_q.last_frame;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule
